cache_control_param: RTL and testbench
======================================

Name: cache_control_param

Overview:
- Parametrised successor to the single-line cache controller FSM: write-through cache sequencing between the processor bus (P_*) and the system bus (S_*).
- Adds:
  - configurable system-bus wait states via an internal down-counter, replacing the separate wait-state counter module;
  - an optional S_ready handshake;
  - selectable write-allocate policy;
  - saturating hit/miss performance counters.
- Sits between the CPU load/store port and the tag/data arrays plus system bus interface.

Parameters:
- WAIT_STATES, 2, system-bus cycles spent in a SYS state (legal range >=1).
- USE_S_READY, 0, 1 = SYS exit additionally requires S_ready high.
- WRITE_ALLOCATE, 0, 1 = write miss also writes the line into the cache.
- CNT_W, 16, width of the hit/miss performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- P_strobe  in  1  processor request; sampled only in IDLE
- P_rw  in  1  1 = read, 0 = write
- P_ready  out  1  one-cycle completion pulse to processor
- Match  in  1  tag compare hit
- Valid  in  1  line valid bit
- S_ready  in  1  system bus ready; ignored when USE_S_READY=0
- Write  out  1  tag/data/valid array write enable
- Cache_data_select  out  1  array write source: 0 = processor bus, 1 = system bus
- P_data_select  out  1  processor bus source: 0 = cache array, 1 = system bus
- P_dataOE  out  1  drive processor data bus
- S_dataOE  out  1  drive system data bus
- S_strobe  out  1  system bus request pulse
- S_rw  out  1  system bus direction: 1 = read, 0 = write
- Busy  out  1  state != IDLE
- Hit_count  out  CNT_W  saturating lookup-hit counter
- Miss_count  out  CNT_W  saturating lookup-miss counter

Behaviour:
- **Reset:** synchronous, active-high.
  - state=IDLE, wait counter=0, Hit_count=Miss_count=0.
  - All outputs 0 in the cycle after rst is sampled.
  - rst mid-transaction aborts it; no P_ready is issued.
- **States:** IDLE, READ, READMISS, READSYS, READDATA, WRITE, WRITEHIT, WRITEMISS, WRITESYS, WRITEDATA.
- **Transitions:**
  - IDLE: P_strobe&&P_rw -> READ; P_strobe&&!P_rw -> WRITE; else stay.
  - READ: Match&&Valid -> IDLE; else READMISS.
  - READMISS -> READSYS.
  - READSYS: exit to READDATA when ctr==0 && (S_ready || !USE_S_READY).
  - READDATA -> IDLE.
  - WRITE: Match&&Valid -> WRITEHIT; else WRITEMISS.
  - WRITEHIT and WRITEMISS -> WRITESYS.
  - WRITESYS: same exit rule as READSYS, to WRITEDATA.
  - WRITEDATA -> IDLE.
  - Unknown encoding -> IDLE with outputs 0.
- **Wait counter:**
  - Width = $clog2(WAIT_STATES+1).
  - Loaded with WAIT_STATES-1 in READMISS, WRITEHIT and WRITEMISS.
  - Decrements each SYS cycle while nonzero; holds at 0.
  - Minimum SYS residency is therefore WAIT_STATES cycles. With USE_S_READY=1, the state stays in SYS until S_ready is high while ctr==0.
- **Outputs (signals not listed = 0):**
  - READ: P_dataOE. P_ready=Match&&Valid (Mealy).
  - READMISS: S_strobe, S_rw.
  - READSYS: S_rw.
  - READDATA: S_rw, Write, Cache_data_select, P_data_select, P_dataOE, P_ready.
  - WRITE: none.
  - WRITEHIT: Write, S_strobe, S_dataOE.
  - WRITEMISS: S_strobe, S_dataOE, Write=WRITE_ALLOCATE.
  - WRITESYS: S_dataOE.
  - WRITEDATA: S_dataOE, P_ready.
- **P_ready:** never held across cycles; exactly one pulse per transaction.
- **Latency:** cycle 0 = IDLE with P_strobe high.
  - Read hit: P_ready in cycle 1.
  - Read miss: P_ready in cycle 3+WAIT_STATES, plus S_ready stall cycles.
  - Write hit or miss: P_ready in cycle 3+WAIT_STATES, plus S_ready stall cycles.
- **Back-to-back requests:** at least one IDLE cycle between transactions. P_strobe outside IDLE is ignored and not queued.
- **Counters:**
  - In READ or WRITE: Match&&Valid increments Hit_count, else Miss_count. Exactly one counter increments per lookup.
  - Both saturate at all-ones (no wrap).
- **Lookup gating:** Match/Valid are sampled only in READ/WRITE; changes elsewhere have no effect.

Test Plan:
- **Read hit:** WAIT_STATES=2; P_strobe=1, P_rw=1, Match=Valid=1 -> READ next cycle, P_ready=1 and P_dataOE=1 in cycle 1, IDLE in cycle 2, Hit_count=1.
- **Read miss:** WAIT_STATES=3, Valid=0 -> S_strobe=1, S_rw=1 in cycle 2; READSYS cycles 3-5; cycle 6 shows Write=1, Cache_data_select=1, P_data_select=1, P_ready=1; Miss_count=1.
- **Write:** WRITE_ALLOCATE=0, write miss -> Write=0 throughout, S_strobe=1 and S_dataOE=1 in cycle 2, P_ready in cycle 3+W. Repeat with WRITE_ALLOCATE=1 -> Write=1 in cycle 2. Write hit -> Write=1, S_strobe=1 in cycle 2.
- **S_ready stall:** USE_S_READY=1, WAIT_STATES=1; hold S_ready=0 for 4 cycles in READSYS -> state remains READSYS, no P_ready; S_ready=1 -> READDATA next cycle.
- **Reset mid-op:** assert rst in WRITESYS -> next cycle IDLE, all outputs 0, counters 0, no P_ready; P_strobe in the same cycle as rst is ignored.
- **Saturation:** CNT_W=2; 5 read hits -> Hit_count sticks at 3, Miss_count=0; P_strobe held high during READ -> one transaction only.

Source files
------------

// File: rtl/cache_control_param_if.sv
// cache_control_param_if: bundles the processor-side, lookup and system-bus signals of the
// write-through cache controller into one port.
//
// Signals
//   P_strobe, P_rw          processor request and direction (1 = read)
//   P_ready                 one-cycle completion pulse to the processor
//   Match, Valid            tag compare result and line valid bit
//   S_ready                 system bus ready
//   Write                   tag/data/valid array write enable
//   Cache_data_select       array write source (0 = processor bus, 1 = system bus)
//   P_data_select           processor bus source (0 = cache array, 1 = system bus)
//   P_dataOE, S_dataOE      data bus output enables
//   S_strobe, S_rw          system bus request pulse and direction (1 = read)
//   Busy                    controller not idle
//   Hit_count, Miss_count   saturating lookup performance counters
//
// Modports
//   master  requester side: drives the request/lookup/ready inputs, observes the controls
//   slave   the controller itself
interface cache_control_param_if #(
    parameter int unsigned CNT_W = 16
) ();

    logic             P_strobe;
    logic             P_rw;
    logic             P_ready;
    logic             Match;
    logic             Valid;
    logic             S_ready;
    logic             Write;
    logic             Cache_data_select;
    logic             P_data_select;
    logic             P_dataOE;
    logic             S_dataOE;
    logic             S_strobe;
    logic             S_rw;
    logic             Busy;
    logic [CNT_W-1:0] Hit_count;
    logic [CNT_W-1:0] Miss_count;

    modport master (
        output P_strobe,
        output P_rw,
        output Match,
        output Valid,
        output S_ready,
        input  P_ready,
        input  Write,
        input  Cache_data_select,
        input  P_data_select,
        input  P_dataOE,
        input  S_dataOE,
        input  S_strobe,
        input  S_rw,
        input  Busy,
        input  Hit_count,
        input  Miss_count
    );

    modport slave (
        input  P_strobe,
        input  P_rw,
        input  Match,
        input  Valid,
        input  S_ready,
        output P_ready,
        output Write,
        output Cache_data_select,
        output P_data_select,
        output P_dataOE,
        output S_dataOE,
        output S_strobe,
        output S_rw,
        output Busy,
        output Hit_count,
        output Miss_count
    );

endinterface

// File: rtl/cache_control_param.sv
// cache_control_param: single-line write-through cache controller sequencing a processor
// load/store port against the tag/data arrays and the system bus.
//
// Parameters
//   WAIT_STATES     minimum cycles spent in a system-bus state (must be >= 1)
//   USE_S_READY     1 = leaving a system-bus state also requires S_ready
//   WRITE_ALLOCATE  1 = a write miss also writes the line into the cache
//   CNT_W           width of the saturating hit/miss counters
//
// Ports
//   clk     clock
//   rst     synchronous active-high reset
//   io_bus  controller side (slave modport) of cache_control_param_if
module cache_control_param #(
    parameter int unsigned WAIT_STATES    = 2,
    parameter bit          USE_S_READY    = 1'b0,
    parameter bit          WRITE_ALLOCATE = 1'b0,
    parameter int unsigned CNT_W          = 16
) (
    input logic                  clk,
    input logic                  rst,
    cache_control_param_if.slave io_bus
);

    localparam int unsigned CTR_W = $clog2(WAIT_STATES + 1);
    // The load value counts the first SYS cycle, so residency is exactly WAIT_STATES.
    localparam logic [CTR_W-1:0] WAIT_LOAD = CTR_W'(WAIT_STATES - 1);

    typedef enum logic [3:0] {
        StIdle      = 4'd0,
        StRead      = 4'd1,
        StReadMiss  = 4'd2,
        StReadSys   = 4'd3,
        StReadData  = 4'd4,
        StWrite     = 4'd5,
        StWriteHit  = 4'd6,
        StWriteMiss = 4'd7,
        StWriteSys  = 4'd8,
        StWriteData = 4'd9
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CTR_W-1:0] r_wait;
    logic [CTR_W-1:0] w_wait_nxt;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] w_hit_cnt_nxt;
    logic [CNT_W-1:0] r_miss_cnt;
    logic [CNT_W-1:0] w_miss_cnt_nxt;

    logic w_lookup_hit;
    logic w_sys_done;
    logic w_lookup;

    logic w_p_ready;
    logic w_write;
    logic w_cache_data_select;
    logic w_p_data_select;
    logic w_p_data_oe;
    logic w_s_data_oe;
    logic w_s_strobe;
    logic w_s_rw;
    logic w_busy;

    assign w_lookup_hit = io_bus.Match && io_bus.Valid;
    assign w_sys_done   = (r_wait == '0) && (io_bus.S_ready || !USE_S_READY);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_wait     <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait     <= w_wait_nxt;
            r_hit_cnt  <= w_hit_cnt_nxt;
            r_miss_cnt <= w_miss_cnt_nxt;
        end
    end

    // Next state and Moore/Mealy outputs.
    always_comb begin
        w_state_nxt         = r_state;
        w_wait_nxt          = r_wait;
        w_lookup            = 1'b0;
        w_p_ready           = 1'b0;
        w_write             = 1'b0;
        w_cache_data_select = 1'b0;
        w_p_data_select     = 1'b0;
        w_p_data_oe         = 1'b0;
        w_s_data_oe         = 1'b0;
        w_s_strobe          = 1'b0;
        w_s_rw              = 1'b0;
        w_busy              = 1'b1;

        unique case (r_state)
            StIdle: begin
                w_busy = 1'b0;
                if (io_bus.P_strobe) begin
                    w_state_nxt = io_bus.P_rw ? StRead : StWrite;
                end
            end
            StRead: begin
                w_lookup    = 1'b1;
                w_p_data_oe = 1'b1;
                // Read hit completes straight from the array in the lookup cycle.
                w_p_ready   = w_lookup_hit;
                w_state_nxt = w_lookup_hit ? StIdle : StReadMiss;
            end
            StReadMiss: begin
                w_s_strobe  = 1'b1;
                w_s_rw      = 1'b1;
                w_wait_nxt  = WAIT_LOAD;
                w_state_nxt = StReadSys;
            end
            StReadSys: begin
                w_s_rw = 1'b1;
                if (r_wait != '0) begin
                    w_wait_nxt = r_wait - CTR_W'(1);
                end
                if (w_sys_done) begin
                    w_state_nxt = StReadData;
                end
            end
            StReadData: begin
                // Line fill from the system bus, forwarded to the processor at the same time.
                w_s_rw              = 1'b1;
                w_write             = 1'b1;
                w_cache_data_select = 1'b1;
                w_p_data_select     = 1'b1;
                w_p_data_oe         = 1'b1;
                w_p_ready           = 1'b1;
                w_state_nxt         = StIdle;
            end
            StWrite: begin
                w_lookup    = 1'b1;
                w_state_nxt = w_lookup_hit ? StWriteHit : StWriteMiss;
            end
            StWriteHit: begin
                w_write     = 1'b1;
                w_s_strobe  = 1'b1;
                w_s_data_oe = 1'b1;
                w_wait_nxt  = WAIT_LOAD;
                w_state_nxt = StWriteSys;
            end
            StWriteMiss: begin
                w_write     = WRITE_ALLOCATE;
                w_s_strobe  = 1'b1;
                w_s_data_oe = 1'b1;
                w_wait_nxt  = WAIT_LOAD;
                w_state_nxt = StWriteSys;
            end
            StWriteSys: begin
                w_s_data_oe = 1'b1;
                if (r_wait != '0) begin
                    w_wait_nxt = r_wait - CTR_W'(1);
                end
                if (w_sys_done) begin
                    w_state_nxt = StWriteData;
                end
            end
            StWriteData: begin
                w_s_data_oe = 1'b1;
                w_p_ready   = 1'b1;
                w_state_nxt = StIdle;
            end
            default: begin
                // Unused encodings recover to idle with every output quiet.
                w_busy      = 1'b0;
                w_wait_nxt  = '0;
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Exactly one counter moves per lookup; both stick at all-ones.
    always_comb begin
        w_hit_cnt_nxt  = r_hit_cnt;
        w_miss_cnt_nxt = r_miss_cnt;
        if (w_lookup) begin
            if (w_lookup_hit) begin
                if (r_hit_cnt != '1) begin
                    w_hit_cnt_nxt = r_hit_cnt + CNT_W'(1);
                end
            end else begin
                if (r_miss_cnt != '1) begin
                    w_miss_cnt_nxt = r_miss_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign io_bus.P_ready           = w_p_ready;
    assign io_bus.Write             = w_write;
    assign io_bus.Cache_data_select = w_cache_data_select;
    assign io_bus.P_data_select     = w_p_data_select;
    assign io_bus.P_dataOE          = w_p_data_oe;
    assign io_bus.S_dataOE          = w_s_data_oe;
    assign io_bus.S_strobe          = w_s_strobe;
    assign io_bus.S_rw              = w_s_rw;
    assign io_bus.Busy              = w_busy;
    assign io_bus.Hit_count         = r_hit_cnt;
    assign io_bus.Miss_count        = r_miss_cnt;

endmodule

// File: tb/tb_cache_control_param.sv
// tb_cache_control_param: several differently parameterised controllers share one random
// input stream; each is compared every cycle against a transaction-level reference model
// that tracks elapsed cycles since the request rather than controller states.
module tb_cache_control_param;

    localparam int NumDut = 5;
    localparam int unsigned CfgWs [NumDut] = '{2, 3, 1, 1, 3};
    localparam bit          CfgUsr[NumDut] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam bit          CfgWa [NumDut] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam int unsigned CfgCw [NumDut] = '{16, 16, 2, 2, 3};
    localparam int NumCycles = 4000;

    logic clk;
    logic rst;
    logic p_strobe;
    logic p_rw;
    logic match;
    logic valid;
    logic s_ready;

    // {P_ready, Write, Cache_data_select, P_data_select, P_dataOE, S_dataOE, S_strobe, S_rw, Busy}
    logic [8:0]  obs_out [NumDut];
    logic [15:0] obs_hit [NumDut];
    logic [15:0] obs_miss[NumDut];

    int n_total;
    int n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NumDut; g++) begin : g_dut
        cache_control_param_if #(.CNT_W(CfgCw[g])) bus ();

        assign bus.P_strobe = p_strobe;
        assign bus.P_rw     = p_rw;
        assign bus.Match    = match;
        assign bus.Valid    = valid;
        assign bus.S_ready  = s_ready;

        cache_control_param #(
            .WAIT_STATES   (CfgWs[g]),
            .USE_S_READY   (CfgUsr[g]),
            .WRITE_ALLOCATE(CfgWa[g]),
            .CNT_W         (CfgCw[g])
        ) u_dut (
            .clk   (clk),
            .rst   (rst),
            .io_bus(bus)
        );

        assign obs_out[g]  = {bus.P_ready, bus.Write, bus.Cache_data_select, bus.P_data_select,
                              bus.P_dataOE, bus.S_dataOE, bus.S_strobe, bus.S_rw, bus.Busy};
        assign obs_hit[g]  = 16'(bus.Hit_count);
        assign obs_miss[g] = 16'(bus.Miss_count);
    end

    // Reference model: one transaction in flight per controller.
    // m_t counts cycles since the request was accepted (1 = lookup cycle, 2 = bus request,
    // 3.. = waiting on the system bus); m_data marks the final completion cycle.
    bit m_busy [NumDut];
    bit m_read [NumDut];
    bit m_hit  [NumDut];
    bit m_data [NumDut];
    int m_t    [NumDut];
    int m_nhit [NumDut];
    int m_nmiss[NumDut];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] model_out(int i);
        logic pr, wr, cds, pds, poe, soe, sst, srw, bsy;
        {pr, wr, cds, pds, poe, soe, sst, srw, bsy} = '0;
        if (m_busy[i]) begin
            bsy = 1'b1;
            if (m_t[i] == 1) begin
                if (m_read[i]) begin
                    poe = 1'b1;
                    pr  = match && valid;
                end
            end else if (m_t[i] == 2) begin
                sst = 1'b1;
                if (m_read[i]) begin
                    srw = 1'b1;
                end else begin
                    soe = 1'b1;
                    wr  = m_hit[i] ? 1'b1 : CfgWa[i];
                end
            end else if (m_data[i]) begin
                pr = 1'b1;
                if (m_read[i]) begin
                    {srw, wr, cds, pds, poe} = 5'b11111;
                end else begin
                    soe = 1'b1;
                end
            end else begin
                if (m_read[i]) srw = 1'b1;
                else           soe = 1'b1;
            end
        end
        return {pr, wr, cds, pds, poe, soe, sst, srw, bsy};
    endfunction

    function automatic int sat(int v, int unsigned w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_step(int i);
        if (rst) begin
            m_busy[i]  = 1'b0;
            m_nhit[i]  = 0;
            m_nmiss[i] = 0;
        end else if (!m_busy[i]) begin
            if (p_strobe) begin
                m_busy[i] = 1'b1;
                m_read[i] = p_rw;
                m_t[i]    = 1;
                m_data[i] = 1'b0;
            end
        end else if (m_t[i] == 1) begin
            m_hit[i] = match && valid;
            if (m_hit[i]) m_nhit[i]++;
            else          m_nmiss[i]++;
            if (m_read[i] && m_hit[i]) m_busy[i] = 1'b0;
            else                       m_t[i] = 2;
        end else if (m_data[i]) begin
            m_busy[i] = 1'b0;
        end else begin
            // System bus phase lasts at least CfgWs cycles, then needs S_ready if enabled.
            if (m_t[i] >= 3 && (m_t[i] - 3) >= int'(CfgWs[i]) - 1 && (s_ready || !CfgUsr[i]))
                m_data[i] = 1'b1;
            m_t[i]++;
        end
    endtask

    initial begin
        n_total  = 0;
        n_bad    = 0;
        rst      = 1'b1;
        p_strobe = 1'b1;
        p_rw     = 1'b1;
        match    = 1'b1;
        valid    = 1'b1;
        s_ready  = 1'b0;
        for (int i = 0; i < NumDut; i++) begin
            m_busy[i]  = 1'b0;
            m_read[i]  = 1'b0;
            m_hit[i]   = 1'b0;
            m_data[i]  = 1'b0;
            m_t[i]     = 0;
            m_nhit[i]  = 0;
            m_nmiss[i] = 0;
        end
        repeat (2) @(posedge clk);

        for (int c = 0; c < NumCycles; c++) begin
            @(negedge clk);
            if (c == 0) begin
                rst = 1'b0;
                p_strobe = 1'b0;
            end else begin
                rst      = ($urandom_range(0, 49) == 0);
                p_strobe = ($urandom_range(0, 9) < 7);
                p_rw     = $urandom_range(0, 1) == 1;
                match    = ($urandom_range(0, 9) < 8);
                valid    = ($urandom_range(0, 9) < 8);
                s_ready  = $urandom_range(0, 1) == 1;
            end
            #1;
            for (int i = 0; i < NumDut; i++) begin
                check_eq($sformatf("dut%0d_ctl_c%0d", i, c), 32'(obs_out[i]), 32'(model_out(i)));
                check_eq($sformatf("dut%0d_hit_c%0d", i, c), 32'(obs_hit[i]),
                         32'(sat(m_nhit[i], CfgCw[i])));
                check_eq($sformatf("dut%0d_miss_c%0d", i, c), 32'(obs_miss[i]),
                         32'(sat(m_nmiss[i], CfgCw[i])));
                model_step(i);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
